// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Holds the FSM state enum and the ms-to-cycles conversion.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } key_state_t;

  function automatic int ms2cyc(input int clkrate, input int ms);
    return clkrate / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: sync, debounce, long-press and auto-repeat.
// Ports: clk, rst, key_raw (active-low pad) in; key_clean, held, press,
// release_evt, longpress, repeat_evt out (all registered).
module key_conditioner
  import key_pkg::*;
#(
  parameter int CLKRATE  = 25000000,
  parameter int DBMSEC   = 20,
  parameter int LONGMSEC = 1000,
  parameter int RPTMSEC  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_clean,
  output logic held,
  output logic press,
  output logic release_evt,
  output logic longpress,
  output logic repeat_evt
);

  localparam int DBMAX   = ms2cyc(CLKRATE, DBMSEC);
  localparam int LONGMAX = ms2cyc(CLKRATE, LONGMSEC);
  localparam int RPTMAX  = ms2cyc(CLKRATE, RPTMSEC);

  generate
    if (DBMAX < 1 || LONGMAX < 1 || RPTMAX < 1) begin : g_bad_cfg
      $error("key_conditioner: derived cycle counts must be >= 1");
    end
  endgenerate

  localparam int DBW = $clog2(DBMAX + 1);
  localparam int HW  = $clog2(LONGMAX + 1);
  localparam int RW  = $clog2(RPTMAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DBMAX - 1);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONGMAX - 1);
  // holdcnt parks at LONGMAX to mark the repeat phase
  localparam logic [HW-1:0]  LONG_SAT  = HW'(LONGMAX);
  localparam logic [RW-1:0]  RPT_LAST  = RW'(RPTMAX - 1);

  logic sync2;
  logic pr_s;

  key_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (sync2)
  );

  assign pr_s = ~sync2;

  key_state_t     state_q, state_d;
  logic [DBW-1:0] dbcnt_q, dbcnt_d;
  logic [HW-1:0]  holdcnt_q, holdcnt_d;
  logic [RW-1:0]  rptcnt_q, rptcnt_d;
  logic           key_clean_q, key_clean_d;
  logic           held_q, held_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;
  logic           long_q, long_d;
  logic           rpt_q, rpt_d;
  logic           hold_run;

  always_comb begin
    state_d   = state_q;
    dbcnt_d   = dbcnt_q;
    holdcnt_d = holdcnt_q;
    rptcnt_d  = rptcnt_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;
    hold_run  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pr_s) begin
          state_d = DB_PRESS;
          dbcnt_d = DBW'(1);
        end
      end
      DB_PRESS: begin
        if (!pr_s) begin
          state_d = IDLE;
          dbcnt_d = '0;
        end else if (dbcnt_q >= DB_LAST) begin
          state_d   = HELD;
          press_d   = 1'b1;
          dbcnt_d   = '0;
          holdcnt_d = '0;
          rptcnt_d  = '0;
        end else begin
          dbcnt_d = dbcnt_q + 1'b1;
        end
      end
      HELD: begin
        hold_run = 1'b1;
        if (!pr_s) begin
          state_d = DB_RELEASE;
          dbcnt_d = DBW'(1);
        end
      end
      DB_RELEASE: begin
        if (pr_s) begin
          state_d  = HELD;
          dbcnt_d  = '0;
          hold_run = 1'b1;
        end else if (dbcnt_q >= DB_LAST) begin
          // committing release suppresses hold events this cycle
          state_d   = IDLE;
          rel_d     = 1'b1;
          dbcnt_d   = '0;
          holdcnt_d = '0;
          rptcnt_d  = '0;
        end else begin
          dbcnt_d  = dbcnt_q + 1'b1;
          hold_run = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dbcnt_d = '0;
      end
    endcase

    if (hold_run) begin
      if (holdcnt_q == LONG_LAST) begin
        holdcnt_d = LONG_SAT;
        long_d    = 1'b1;
        rptcnt_d  = '0;
      end else if (holdcnt_q == LONG_SAT) begin
        if (rptcnt_q == RPT_LAST) begin
          rpt_d    = 1'b1;
          rptcnt_d = '0;
        end else begin
          rptcnt_d = rptcnt_q + 1'b1;
        end
      end else begin
        holdcnt_d = holdcnt_q + 1'b1;
      end
    end

    held_d      = (state_d == HELD) || (state_d == DB_RELEASE);
    key_clean_d = ~held_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dbcnt_q     <= '0;
      holdcnt_q   <= '0;
      rptcnt_q    <= '0;
      key_clean_q <= 1'b1;
      held_q      <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dbcnt_q     <= dbcnt_d;
      holdcnt_q   <= holdcnt_d;
      rptcnt_q    <= rptcnt_d;
      key_clean_q <= key_clean_d;
      held_q      <= held_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
      rpt_q       <= rpt_d;
    end
  end

  assign key_clean   = key_clean_q;
  assign held        = held_q;
  assign press       = press_q;
  assign release_evt = rel_q;
  assign longpress   = long_q;
  assign repeat_evt  = rpt_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at CLKRATE=1000, DB=4, LONG=20, RPT=5.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_key_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic key_raw;
  logic key_clean;
  logic held;
  logic press;
  logic release_evt;
  logic longpress;
  logic repeat_evt;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .CLKRATE  (1000),
    .DBMSEC   (4),
    .LONGMSEC (20),
    .RPTMSEC  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_clean   (key_clean),
    .held        (held),
    .press       (press),
    .release_evt (release_evt),
    .longpress   (longpress),
    .repeat_evt  (repeat_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({key_clean, held, press, release_evt, longpress, repeat_evt}
          !== 6'b100000) begin
        errors++;
        $display("FAIL reset k=%0d got kc=%b h=%b p=%b r=%b l=%b rp=%b want 100000",
                 k, key_clean, held, press, release_evt, longpress, repeat_evt);
      end
    end
    key_raw = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (key_clean !== 1'b1 || held !== 1'b0 || press !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got kc=%b h=%b p=%b", k,
                 key_clean, held, press);
      end
    end
  endtask

  task automatic test_clean_press();
    key_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (press !== (k == 6)) begin
        errors++;
        $display("FAIL press k=%0d got %b want %b", k, press, (k == 6));
      end
      checks++;
      if (key_clean !== (k != 6) || held !== (k == 6)) begin
        errors++;
        $display("FAIL press_level k=%0d got kc=%b h=%b", k, key_clean, held);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic exp_rpt;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_rpt = (k >= 25) && ((k - 20) % 5 == 0);
      checks++;
      if (longpress !== (k == 20)) begin
        errors++;
        $display("FAIL longpress k=%0d got %b want %b", k, longpress, (k == 20));
      end
      checks++;
      if (repeat_evt !== exp_rpt) begin
        errors++;
        $display("FAIL repeat k=%0d got %b want %b", k, repeat_evt, exp_rpt);
      end
      checks++;
      if (press !== 1'b0 || held !== 1'b1 || release_evt !== 1'b0) begin
        errors++;
        $display("FAIL hold_level k=%0d got p=%b h=%b r=%b want 0 1 0", k,
                 press, held, release_evt);
      end
    end
  endtask

  task automatic test_release();
    key_raw = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    key_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (release_evt !== 1'b0 || held !== 1'b1 || key_clean !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d got r=%b h=%b kc=%b want 0 1 0", k,
                 release_evt, held, key_clean);
      end
    end
    key_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (release_evt !== (k == 6)) begin
        errors++;
        $display("FAIL release k=%0d got %b want %b", k, release_evt, (k == 6));
      end
      checks++;
      if (key_clean !== (k == 6) || held !== (k != 6)) begin
        errors++;
        $display("FAIL release_level k=%0d got kc=%b h=%b", k, key_clean, held);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (release_evt !== 1'b0 || key_clean !== 1'b1) begin
        errors++;
        $display("FAIL post_release k=%0d got r=%b kc=%b want 0 1", k,
                 release_evt, key_clean);
      end
    end
  endtask

  task automatic test_bounce();
    key_raw = 1'b0;
    tick();
    tick();
    key_raw = 1'b1;
    tick();
    key_raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (press !== (k == 6) || held !== (k == 6)) begin
        errors++;
        $display("FAIL bounce k=%0d got p=%b h=%b want %b", k, press, held,
                 (k == 6));
      end
    end
    key_raw = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    checks++;
    if (held !== 1'b0 || key_clean !== 1'b1) begin
      errors++;
      $display("FAIL bounce_release got h=%b kc=%b want 0 1", held, key_clean);
    end
  endtask

  task automatic test_reset_mid_hold();
    key_raw = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    checks++;
    if (press !== 1'b1) begin
      errors++;
      $display("FAIL rmh_press got %b want 1", press);
    end
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if ({key_clean, held, press, release_evt, longpress, repeat_evt}
          !== 6'b100000) begin
        errors++;
        $display("FAIL reset_mid_hold k=%0d got kc=%b h=%b p=%b r=%b l=%b rp=%b",
                 k, key_clean, held, press, release_evt, longpress, repeat_evt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_long_repeat();
    test_release();
    test_bounce();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end conditioner for a raw push-button pin, sitting directly upstream of the SoC buttom bus interface. It synchronises the asynchronous pad signal, debounces both press and release, and drives a clean active-low level into the buttom block's `key` input. It also produces single-cycle press, release, long-press and auto-repeat event pulses for future bus-visible status registers.

## Interface
- `CLKRATE`, 25000000, clock frequency in Hz
- `DBMSEC`, 20, debounce window in ms (press and release)
- `LONGMSEC`, 1000, hold time in ms before the long-press event
- `RPTMSEC`, 200, auto-repeat period in ms after the long press
- `clk` input 1 system clock, all logic on rising edge
- `rst` input 1 reset, synchronous, active-high
- `key_raw` input 1 asynchronous pad signal, active-low (0 = pressed)
- `key_clean` output 1 debounced level, active-low, to buttom `key`
- `held` output 1 high while debounced state is pressed
- `press` output 1 one-cycle pulse on debounced press
- `release` output 1 one-cycle pulse on debounced release
- `longpress` output 1 one-cycle pulse when hold reaches LONGMSEC
- `repeat` output 1 one-cycle pulse every RPTMSEC after longpress while held

## Operation
- Derived constants: DBMAX = CLKRATE/1000*DBMSEC, LONGMAX = CLKRATE/1000*LONGMSEC, RPTMAX = CLKRATE/1000*RPTMSEC. All must be ≥1 (elaboration-time assertion). Each counter width is $clog2(MAX+1).
- Synchroniser: two flops on `key_raw`. `pr_s` = ~sync2 (1 = pressed). Both flops reset to 1 (released).
- FSM states:
  - IDLE: pr_s=1 → DB_PRESS, dbcnt=1.
  - DB_PRESS: pr_s=0 → IDLE, dbcnt=0. pr_s=1 and dbcnt==DBMAX-1 → HELD, `press` pulses, holdcnt=0. Otherwise dbcnt++.
  - HELD: pr_s=0 → DB_RELEASE, dbcnt=1. Otherwise holdcnt advances.
  - DB_RELEASE: pr_s=1 → HELD, dbcnt=0, holdcnt preserved. pr_s=0 and dbcnt==DBMAX-1 → IDLE, `release` pulses. Otherwise dbcnt++.
- DBMAX==1: a one-cycle stable sample commits. DB_PRESS and DB_RELEASE are then transit states of one cycle each.
- Hold counting runs in HELD and DB_RELEASE:
  - holdcnt counts to LONGMAX-1, then `longpress` fires once and the repeat phase starts with rptcnt=0.
  - In the repeat phase, rptcnt reaching RPTMAX-1 fires `repeat` and wraps rptcnt to 0.
  - holdcnt saturates and never wraps.
- `held` = state ∈ {HELD, DB_RELEASE}. `key_clean` = ~held.
- At most one of press/release/longpress/repeat is high in any cycle.

## Timing
- Reset values: state IDLE, all counters 0, sync flops 1, `key_clean`=1, all other outputs 0. `rst` mid-operation aborts immediately with no release pulse.
- Stable pad press to `press`/`held`/`key_clean`=0: 2 (sync) + DBMAX cycles after the pad edge. All outputs are registered.
- Release latency is symmetric: 2 + DBMAX cycles to `release`.
- `longpress` fires LONGMAX cycles after the `press` cycle.
- The first `repeat` fires RPTMAX cycles after `longpress`, then every RPTMAX cycles.
- Any bounce shorter than DBMAX restarts the debounce window. A pulse narrower than one clock may be missed.

## Structure
- Package `key_pkg`:
  - state enum `key_state_t` {IDLE, DB_PRESS, HELD, DB_RELEASE}
  - function `ms2cyc(clkrate, ms)` for the derived constants
- Sub-module `key_sync`: 2-flop synchroniser with parameterised reset value. Instantiated once.

## Test plan
All scenarios use CLKRATE=1000, DBMSEC=4, LONGMSEC=20, RPTMSEC=5.
1. Reset check: assert `rst` with `key_raw`=0 → after reset, `key_clean`=1, `held`=0, no pulses for the full reset period.
2. Clean press: drive `key_raw` 1→0 and hold → `press` high exactly 6 cycles after the edge, `key_clean`=0 the same cycle.
3. Bounce on press: 0 for 2 cycles, 1 for 1 cycle, then 0 steady → no `press` until 6 cycles after the final falling edge.
4. Long press and repeat: hold 40 cycles past `press` → `longpress` at press+20, `repeat` at press+25, +30, +35, +40.
5. Release glitch then release: while held, 1 for 3 cycles then back to 0 → no `release`, `held` stays 1. Final 0→1 held steady → `release` 6 cycles after the edge, `key_clean`=1.
6. Reset mid-hold: assert `rst` in HELD at holdcnt=10 → next cycle state IDLE, `key_clean`=1, no `release`/`longpress` pulse.
